mac_feeder: RTL and testbench

Operand sequencer and result collector on the initiator side of the `mac` interface. Accepts a job length and a stream of (data, weight) byte pairs, assembles them into the flattened operand vectors `mac` expects, and holds `valid_in` until `mac` answers with `valid_out`. It then captures `mac_out` and presents it on a valid/ready result port. Sits between the operand buffer/DMA path and the `mac` array.

---
 rtl/mac_pkg.sv | 24 ++
 rtl/mac_operand_buf.sv | 57 +++++
 rtl/mac_feeder.sv | 143 ++++++++++++++
 tb/tb_mac_feeder.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared constants, feeder state encoding and lane-slice helper
// for the mac operand path.
//   DATA_WIDTH  - signed operand width (results are 2*DATA_WIDTH)
//   MAX_MACS    - number of operand lanes and the largest legal job length
//   NUM_MACS_W  - width of the job-length field
package mac_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int MAX_MACS   = 64;
  localparam int NUM_MACS_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_RESULT = 2'd3
  } feeder_state_e;

  // LSB position of a lane inside a flattened lane vector.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/mac_operand_buf.sv
// mac_operand_buf: per-lane data/weight registers presented as flattened
// vectors for the mac array.
//   clk, rst          - clock, synchronous active-high reset
//   clear_i           - zero every lane (start of a new job)
//   wr_en_i, lane_i   - write data_i/weight_i into lane lane_i
//   data_o, weight_o  - all lanes, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
module mac_operand_buf #(
  parameter int DATA_WIDTH = mac_pkg::DATA_WIDTH,
  parameter int MAX_MACS   = mac_pkg::MAX_MACS,
  parameter int LANE_W     = $clog2(MAX_MACS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear_i,
  input  logic                           wr_en_i,
  input  logic [LANE_W-1:0]              lane_i,
  input  logic [DATA_WIDTH-1:0]          data_i,
  input  logic [DATA_WIDTH-1:0]          weight_i,
  output logic [MAX_MACS*DATA_WIDTH-1:0] data_o,
  output logic [MAX_MACS*DATA_WIDTH-1:0] weight_o
);
  import mac_pkg::*;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_MACS; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] data_q, data_d;
      logic [DATA_WIDTH-1:0] weight_q, weight_d;

      always_comb begin
        data_d   = data_q;
        weight_d = weight_q;
        if (clear_i) begin
          data_d   = '0;
          weight_d = '0;
        end else if (wr_en_i && (lane_i == LANE_W'(gi))) begin
          data_d   = data_i;
          weight_d = weight_i;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          data_q   <= '0;
          weight_q <= '0;
        end else begin
          data_q   <= data_d;
          weight_q <= weight_d;
        end
      end

      assign data_o[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH]   = data_q;
      assign weight_o[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] = weight_q;
    end
  endgenerate

endmodule

// File: rtl/mac_feeder.sv
// mac_feeder: loads a job of N (data, weight) beats into the operand lanes,
// holds valid to the mac array until it answers, then offers the captured
// result on a valid/ready port.
//   start_i/num_macs_i       - job request and length (IDLE only)
//   in_valid_i/in_ready_o    - operand beat handshake, in_data_i/in_weight_i
//   num_macs_o, mac_valid_o, data_o, weight_o - to the mac array
//   mac_out_i, mac_valid_i   - from the mac array
//   res_valid_o/res_ready_i  - result handshake, res_data_o
//   busy_o                   - not IDLE;  err_o - pulse on illegal length
module mac_feeder #(
  parameter int MAX_MACS   = mac_pkg::MAX_MACS,
  parameter int DATA_WIDTH = mac_pkg::DATA_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start_i,
  input  logic [mac_pkg::NUM_MACS_W-1:0]        num_macs_i,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic [DATA_WIDTH-1:0]                 in_data_i,
  input  logic [DATA_WIDTH-1:0]                 in_weight_i,
  output logic [mac_pkg::NUM_MACS_W-1:0]        num_macs_o,
  output logic                                  mac_valid_o,
  output logic [MAX_MACS*DATA_WIDTH-1:0]        data_o,
  output logic [MAX_MACS*DATA_WIDTH-1:0]        weight_o,
  input  logic [2*DATA_WIDTH-1:0]               mac_out_i,
  input  logic                                  mac_valid_i,
  output logic                                  res_valid_o,
  input  logic                                  res_ready_i,
  output logic signed [2*DATA_WIDTH-1:0]        res_data_o,
  output logic                                  busy_o,
  output logic                                  err_o
);
  import mac_pkg::*;

  localparam int LANE_W = $clog2(MAX_MACS);

  feeder_state_e           state_q, state_d;
  logic [NUM_MACS_W-1:0]   num_macs_q, num_macs_d;
  logic [LANE_W-1:0]       cnt_q, cnt_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;
  logic                    err_q, err_d;
  logic                    in_ready_q, mac_valid_q, res_valid_q, busy_q;
  logic                    clear, wr_en;

  always_comb begin
    state_d    = state_q;
    num_macs_d = num_macs_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    err_d      = 1'b0;
    clear      = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if ((num_macs_i != '0) && (num_macs_i <= NUM_MACS_W'(MAX_MACS))) begin
            state_d    = ST_LOAD;
            num_macs_d = num_macs_i;
            cnt_d      = '0;
            clear      = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (in_valid_i) begin
          wr_en = 1'b1;
          // For N = MAX_MACS the counter wraps to 0 here; it is unused
          // until the next job clears it anyway.
          cnt_d = cnt_q + 1'b1;
          if (NUM_MACS_W'(cnt_q) == (num_macs_q - 1'b1)) begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (mac_valid_i) begin
          res_d   = mac_out_i;
          state_d = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (res_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they change
  // exactly with the state register and never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      num_macs_q  <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      mac_valid_q <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_macs_q  <= num_macs_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      err_q       <= err_d;
      in_ready_q  <= (state_d == ST_LOAD);
      mac_valid_q <= (state_d == ST_ISSUE);
      res_valid_q <= (state_d == ST_RESULT);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  mac_operand_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_MACS   (MAX_MACS),
    .LANE_W     (LANE_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (clear),
    .wr_en_i  (wr_en),
    .lane_i   (cnt_q),
    .data_i   (in_data_i),
    .weight_i (in_weight_i),
    .data_o   (data_o),
    .weight_o (weight_o)
  );

  assign num_macs_o  = num_macs_q;
  assign in_ready_o  = in_ready_q;
  assign mac_valid_o = mac_valid_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mac_feeder.sv
module tb_mac_feeder;
  localparam int DW = 8;
  localparam int MM = 64;
  localparam int NW = 11;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic [NW-1:0]     num_macs_i = '0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [DW-1:0]     in_data_i = '0;
  logic [DW-1:0]     in_weight_i = '0;
  logic [NW-1:0]     num_macs_o;
  logic              mac_valid_o;
  logic [MM*DW-1:0]  data_o;
  logic [MM*DW-1:0]  weight_o;
  logic [2*DW-1:0]   mac_out_i = '0;
  logic              mac_valid_i = 1'b0;
  logic              res_valid_o;
  logic              res_ready_i = 1'b0;
  logic signed [2*DW-1:0] res_data_o;
  logic              busy_o;
  logic              err_o;

  mac_feeder dut (
    .clk(clk), .rst(rst), .start_i(start_i), .num_macs_i(num_macs_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .in_weight_i(in_weight_i),
    .num_macs_o(num_macs_o), .mac_valid_o(mac_valid_o),
    .data_o(data_o), .weight_o(weight_o),
    .mac_out_i(mac_out_i), .mac_valid_i(mac_valid_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic mv_before = 1'b0;
  logic signed [DW-1:0] d_arr [MM];
  logic signed [DW-1:0] w_arr [MM];
  logic [2*DW-1:0] exp_q [$];

  // Behavioural mac: answers once valid_in has been high for mac_lat cycles.
  bit mac_auto = 1'b1;
  int mac_lat = 3;
  int hi_cnt = 0;
  int mdl_acc;
  always @(negedge clk) begin
    if (mac_auto) begin
      if (mac_valid_o) begin
        hi_cnt++;
        mdl_acc = 0;
        for (int i = 0; i < MM; i++)
          if (i < int'(num_macs_o))
            mdl_acc += int'($signed(data_o[i*DW +: DW])) * int'($signed(weight_o[i*DW +: DW]));
        mac_out_i   = mdl_acc[2*DW-1:0];
        mac_valid_i = (hi_cnt == mac_lat + 1);
      end else begin
        hi_cnt      = 0;
        mac_valid_i = 1'b0;
      end
    end
  end

  task automatic tick();
    mv_before = mac_valid_o;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [2*DW-1:0] expected_sum(input int n);
    int acc = 0;
    for (int i = 0; i < n; i++) acc += int'(d_arr[i]) * int'(w_arr[i]);
    return acc[2*DW-1:0];
  endfunction

  task automatic send_start(input int n);
    start_i = 1'b1;
    num_macs_i = NW'(n);
    tick();
    start_i = 1'b0;
  endtask

  task automatic send_beats(input int n, input bit gap);
    exp_q.push_back(expected_sum(n));
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) begin
        in_valid_i = 1'b0;
        in_data_i = 8'h5A;
        in_weight_i = 8'hA5;
        tick();
      end
      in_valid_i = 1'b1;
      in_data_i = d_arr[i];
      in_weight_i = w_arr[i];
      tick();
    end
    in_valid_i = 1'b0;
  endtask

  task automatic wait_res(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (res_valid_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic finish_res();
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy_o, in_ready_o, mac_valid_o, res_valid_o, err_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got=%b want=00000", {busy_o, in_ready_o, mac_valid_o, res_valid_o, err_o});
    end
    checks++;
    if (num_macs_o !== '0 || res_data_o !== '0) begin
      errors++; $display("FAIL reset_regs num=%0d res=%0d want 0/0", num_macs_o, res_data_o);
    end
    checks++;
    if (data_o !== '0 || weight_o !== '0) begin
      errors++; $display("FAIL reset_lanes got nonzero lanes want 0");
    end
    rst = 1'b0;
    tick();
    $display("reset: checked idle state");
  endtask

  task automatic test_single();
    bit ok;
    int hi;
    logic [2*DW-1:0] e;
    d_arr[0] = -8'sd99;
    w_arr[0] = 8'sd64;
    send_start(1);
    checks++;
    if (busy_o !== 1'b1 || in_ready_o !== 1'b1) begin
      errors++; $display("FAIL single_load busy=%b ready=%b want 1/1", busy_o, in_ready_o);
    end
    send_beats(1, 1'b0);
    checks++;
    if (data_o[MM*DW-1:DW] !== '0 || weight_o[MM*DW-1:DW] !== '0) begin
      errors++; $display("FAIL single_upper_lanes got nonzero want 0");
    end
    checks++;
    if (data_o[DW-1:0] !== 8'h9D || weight_o[DW-1:0] !== 8'h40 || num_macs_o !== 11'd1) begin
      errors++; $display("FAIL single_lane0 d=%h w=%h n=%0d want 9d/40/1", data_o[DW-1:0], weight_o[DW-1:0], num_macs_o);
    end
    hi = 0;
    while (mac_valid_o && hi < 20) begin
      hi++;
      tick();
    end
    checks++;
    if (hi !== 4) begin
      errors++; $display("FAIL single_valid_len got=%0d want=4", hi);
    end
    wait_res(ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin
      errors++; $display("FAIL single_timeout ok=%0d q=%0d want result", ok, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (res_data_o !== e || res_data_o !== -16'sd6336) begin
        errors++; $display("FAIL single_result got=%0d want=%0d", res_data_o, $signed(e));
      end
    end
    finish_res();
    checks++;
    if (busy_o !== 1'b0 || res_valid_o !== 1'b0) begin
      errors++; $display("FAIL single_idle busy=%b resv=%b want 0/0", busy_o, res_valid_o);
    end
    $display("single: N=1 result %0d", res_data_o);
  endtask

  task automatic test_full64();
    bit ok;
    int s;
    logic [2*DW-1:0] e;
    for (int i = 0; i < MM; i++) begin
      d_arr[i] = DW'(i - 99);
      w_arr[i] = DW'(64 - i);
    end
    s = cyc;
    send_start(64);
    send_beats(64, 1'b0);
    checks++;
    if (mv_before !== 1'b0 || mac_valid_o !== 1'b1 || (cyc - s) !== 65) begin
      errors++; $display("FAIL full_rise prev=%b now=%b at=%0d want 0/1 at 65", mv_before, mac_valid_o, cyc - s);
    end
    checks++;
    if (data_o[63*DW +: DW] !== 8'hDC || weight_o[63*DW +: DW] !== 8'h01) begin
      errors++; $display("FAIL full_lane63 got=(%0d,%0d) want=(-36,1)", $signed(data_o[63*DW +: DW]), $signed(weight_o[63*DW +: DW]));
    end
    for (int i = 0; i < MM; i++) begin
      checks++;
      if (data_o[i*DW +: DW] !== d_arr[i] || weight_o[i*DW +: DW] !== w_arr[i]) begin
        errors++; $display("FAIL full_lane%0d got=(%h,%h) want=(%h,%h)", i, data_o[i*DW +: DW], weight_o[i*DW +: DW], d_arr[i], w_arr[i]);
      end
    end
    wait_res(ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin
      errors++; $display("FAIL full_timeout ok=%0d want result", ok);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (res_data_o !== e) begin
        errors++; $display("FAIL full_result got=%h want=%h", res_data_o, e);
      end
    end
    finish_res();
    $display("full64: result %h", res_data_o);
  endtask

  task automatic test_stall();
    bit ok;
    logic [2*DW-1:0] e;
    logic [2*DW-1:0] held;
    for (int i = 0; i < 5; i++) begin
      d_arr[i] = DW'(7 * i - 20);
      w_arr[i] = DW'(-3 - 11 * i);
    end
    send_start(5);
    send_beats(5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (data_o[i*DW +: DW] !== d_arr[i] || weight_o[i*DW +: DW] !== w_arr[i]) begin
        errors++; $display("FAIL stall_lane%0d got=(%h,%h) want=(%h,%h)", i, data_o[i*DW +: DW], weight_o[i*DW +: DW], d_arr[i], w_arr[i]);
      end
    end
    checks++;
    if (data_o[MM*DW-1:5*DW] !== '0) begin
      errors++; $display("FAIL stall_upper got nonzero want 0");
    end
    wait_res(ok);
    held = res_data_o;
    checks++;
    if (!ok || exp_q.size() == 0) begin
      errors++; $display("FAIL stall_timeout ok=%0d want result", ok);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (res_data_o !== e) begin
        errors++; $display("FAIL stall_result got=%h want=%h", res_data_o, e);
      end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (res_valid_o !== 1'b1 || res_data_o !== held || mac_valid_o !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d v=%b d=%h mv=%b want 1/%h/0", i, res_valid_o, res_data_o, mac_valid_o, held);
      end
      tick();
    end
    finish_res();
    checks++;
    if (busy_o !== 1'b0 || res_valid_o !== 1'b0) begin
      errors++; $display("FAIL stall_idle busy=%b resv=%b want 0/0", busy_o, res_valid_o);
    end
    $display("stall: N=5 result %h held 5 cycles", held);
  endtask

  task automatic test_bad_len();
    int lens [2];
    lens[0] = 0;
    lens[1] = 65;
    for (int k = 0; k < 2; k++) begin
      send_start(lens[k]);
      checks++;
      if (err_o !== 1'b1 || busy_o !== 1'b0 || in_ready_o !== 1'b0) begin
        errors++; $display("FAIL badlen%0d_pulse err=%b busy=%b rdy=%b want 1/0/0", lens[k], err_o, busy_o, in_ready_o);
      end
      tick();
      checks++;
      if (err_o !== 1'b0 || busy_o !== 1'b0 || mac_valid_o !== 1'b0) begin
        errors++; $display("FAIL badlen%0d_after err=%b busy=%b mv=%b want 0/0/0", lens[k], err_o, busy_o, mac_valid_o);
      end
      $display("bad_len: N=%0d rejected", lens[k]);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    logic [2*DW-1:0] e;
    send_start(20);
    for (int i = 0; i < 10; i++) begin
      in_valid_i = 1'b1;
      in_data_i = DW'(i + 1);
      in_weight_i = 8'd2;
      tick();
    end
    in_valid_i = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if ({busy_o, in_ready_o, mac_valid_o, res_valid_o, err_o} !== 5'b0 || num_macs_o !== '0 || res_data_o !== '0) begin
      errors++; $display("FAIL midrst_ctrl flags=%b n=%0d r=%0d want 0", {busy_o, in_ready_o, mac_valid_o, res_valid_o, err_o}, num_macs_o, res_data_o);
    end
    checks++;
    if (data_o !== '0 || weight_o !== '0) begin
      errors++; $display("FAIL midrst_lanes got nonzero want 0");
    end
    rst = 1'b0;
    d_arr[0] = 8'sd3; w_arr[0] = 8'sd4;
    d_arr[1] = 8'sd5; w_arr[1] = 8'sd6;
    send_start(2);
    send_beats(2, 1'b0);
    wait_res(ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin
      errors++; $display("FAIL midrst_timeout ok=%0d want result", ok);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (res_data_o !== e || res_data_o !== 16'sd42) begin
        errors++; $display("FAIL midrst_result got=%0d want=42", res_data_o);
      end
    end
    finish_res();
    $display("mid_reset: follow-up job result %0d", res_data_o);
  endtask

  task automatic test_spurious();
    bit ok;
    logic [2*DW-1:0] e;
    mac_auto = 1'b0;
    mac_valid_i = 1'b1;
    mac_out_i = 16'h1234;
    tick();
    mac_valid_i = 1'b0;
    checks++;
    if (res_valid_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0) begin
      errors++; $display("FAIL spur_idle resv=%b busy=%b err=%b want 0/0/0", res_valid_o, busy_o, err_o);
    end
    d_arr[0] = 8'sd10; w_arr[0] = -8'sd2;
    d_arr[1] = -8'sd7; w_arr[1] = 8'sd9;
    d_arr[2] = 8'sd127; w_arr[2] = -8'sd128;
    exp_q.push_back(expected_sum(3));
    send_start(3);
    in_valid_i = 1'b1; in_data_i = d_arr[0]; in_weight_i = w_arr[0];
    tick();
    in_valid_i = 1'b0;
    mac_valid_i = 1'b1;
    start_i = 1'b1;
    num_macs_i = 11'd1;
    tick();
    mac_valid_i = 1'b0;
    start_i = 1'b0;
    checks++;
    if (in_ready_o !== 1'b1 || err_o !== 1'b0 || res_valid_o !== 1'b0 || num_macs_o !== 11'd3) begin
      errors++; $display("FAIL spur_load rdy=%b err=%b resv=%b n=%0d want 1/0/0/3", in_ready_o, err_o, res_valid_o, num_macs_o);
    end
    for (int i = 1; i < 3; i++) begin
      in_valid_i = 1'b1; in_data_i = d_arr[i]; in_weight_i = w_arr[i];
      tick();
    end
    in_valid_i = 1'b0;
    start_i = 1'b1;
    num_macs_i = 11'd7;
    tick();
    start_i = 1'b0;
    checks++;
    if (mac_valid_o !== 1'b1 || err_o !== 1'b0 || num_macs_o !== 11'd3 || res_valid_o !== 1'b0) begin
      errors++; $display("FAIL spur_issue mv=%b err=%b n=%0d resv=%b want 1/0/3/0", mac_valid_o, err_o, num_macs_o, res_valid_o);
    end
    mac_auto = 1'b1;
    wait_res(ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin
      errors++; $display("FAIL spur_timeout ok=%0d want result", ok);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (res_data_o !== e) begin
        errors++; $display("FAIL spur_result got=%h want=%h", res_data_o, e);
      end
    end
    finish_res();
    $display("spurious: ignored start/mac_valid, result %h", res_data_o);
  endtask

  initial begin
    test_reset();
    test_single();
    test_full64();
    test_stall();
    test_bad_len();
    test_mid_reset();
    test_spurious();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
